// File: rtl/router_input_fifo.sv
// Per-port router input buffer: DRTS/CTS two-phase receive into a circular FIFO,
// head flit presented combinationally to the crossbar, popped by arbiter grants.
module router_input_fifo #(
  parameter int unsigned  DATA_WIDTH = 32,
  parameter int unsigned  DEPTH      = 4,
  localparam int unsigned PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  DRTS,
  input  logic [DATA_WIDTH-1:0] RX,
  output logic                  CTS,
  input  logic                  read_en_N,
  input  logic                  read_en_E,
  input  logic                  read_en_W,
  input  logic                  read_en_S,
  input  logic                  read_en_L,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  empty,
  output logic                  full,
  output logic [PTR_W:0]        count
);

  localparam logic [PTR_W:0] CountFull = (PTR_W + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_rd_ptr, r_wr_ptr;
  logic [PTR_W:0]        r_count;
  logic                  r_cts;

  logic                  w_read_en;
  logic                  w_write;
  logic                  w_read;
  logic                  w_cts_next;
  logic [PTR_W:0]        w_count_next;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CountFull);
  assign count     = r_count;
  assign CTS       = r_cts;
  assign Data_out  = r_mem[r_rd_ptr];

  assign w_read_en = read_en_N | read_en_E | read_en_W | read_en_S | read_en_L;
  // A withdrawn DRTS during the CTS cycle drops the flit.
  assign w_write   = r_cts & DRTS;
  assign w_read    = w_read_en & ~empty;

  always_comb begin
    // Full is checked only when raising CTS; occupancy can only fall before the write.
    w_cts_next = ~r_cts & DRTS & ~full;
    w_count_next = r_count;
    unique case ({w_write, w_read})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cts    <= 1'b0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_cts   <= w_cts_next;
      r_count <= w_count_next;
      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_read)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_write && !rst) r_mem[r_wr_ptr] <= RX;
  end

endmodule

// File: tb/tb_router_input_fifo.sv
// Directed self-checking bench for router_input_fifo (DATA_WIDTH=32, DEPTH=4).
module tb_router_input_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        DRTS;
  logic [31:0] RX;
  logic        CTS;
  logic        read_en_N, read_en_E, read_en_W, read_en_S, read_en_L;
  logic [31:0] Data_out;
  logic        empty, full;
  logic [2:0]  count;

  int n_pass  = 0;
  int n_total = 0;

  router_input_fifo #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .DRTS      (DRTS),
    .RX        (RX),
    .CTS       (CTS),
    .read_en_N (read_en_N),
    .read_en_E (read_en_E),
    .read_en_W (read_en_W),
    .read_en_S (read_en_S),
    .read_en_L (read_en_L),
    .Data_out  (Data_out),
    .empty     (empty),
    .full      (full),
    .count     (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  // Advance one edge; inputs set after return apply to the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Hold DRTS until CTS, keep it through the write edge, then drop it.
  task automatic send_flit(input logic [31:0] d);
    int waited = 0;
    DRTS = 1'b1;
    RX   = d;
    while (CTS !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    n_total++;
    if (CTS !== 1'b1) $display("FAIL send_cts_timeout: CTS=%b required 1 for flit %h", CTS, d);
    else n_pass++;
    tick();
    DRTS = 1'b0;
  endtask

  task automatic pop_n(input logic [31:0] exp);
    n_total++;
    if (Data_out !== exp) $display("FAIL pop_head: Data_out=%h required %h", Data_out, exp);
    else n_pass++;
    read_en_N = 1'b1;
    tick();
    read_en_N = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_total++;
    if (CTS !== 1'b0) $display("FAIL reset_cts: CTS=%b required 0", CTS); else n_pass++;
    n_total++;
    if (count !== 3'd0) $display("FAIL reset_count: count=%0d required 0", count); else n_pass++;
    n_total++;
    if (empty !== 1'b1) $display("FAIL reset_empty: empty=%b required 1", empty); else n_pass++;
    n_total++;
    if (full !== 1'b0) $display("FAIL reset_full: full=%b required 0", full); else n_pass++;
  endtask

  task automatic test_single_write();
    DRTS = 1'b1;
    RX   = 32'hA5A5_0001;
    tick();
    n_total++;
    if (CTS !== 1'b1) $display("FAIL single_cts_rise: CTS=%b required 1", CTS); else n_pass++;
    n_total++;
    if (count !== 3'd0) $display("FAIL single_count0: count=%0d required 0", count); else n_pass++;
    tick();
    DRTS = 1'b0;
    n_total++;
    if (CTS !== 1'b0) $display("FAIL single_cts_fall: CTS=%b required 0", CTS); else n_pass++;
    n_total++;
    if (count !== 3'd1) $display("FAIL single_count1: count=%0d required 1", count); else n_pass++;
    n_total++;
    if (empty !== 1'b0) $display("FAIL single_empty: empty=%b required 0", empty); else n_pass++;
    n_total++;
    if (Data_out !== 32'hA5A5_0001)
      $display("FAIL single_data: Data_out=%h required a5a50001", Data_out);
    else n_pass++;
    pop_n(32'hA5A5_0001);
    n_total++;
    if (empty !== 1'b1) $display("FAIL single_drain: empty=%b required 1", empty); else n_pass++;
  endtask

  task automatic test_fill_full();
    DRTS = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      RX = 32'(i);
      tick();
      n_total++;
      if (CTS !== 1'b1) $display("FAIL fill_cts_hi[%0d]: CTS=%b required 1", i, CTS);
      else n_pass++;
      tick();
      n_total++;
      if (CTS !== 1'b0 || count !== 3'(i))
        $display("FAIL fill_write[%0d]: CTS=%b count=%0d required CTS=0 count=%0d",
                 i, CTS, count, i);
      else n_pass++;
    end
    RX = 32'd5;
    tick();
    tick();
    n_total++;
    if (CTS !== 1'b0 || full !== 1'b1)
      $display("FAIL full_hold: CTS=%b full=%b required CTS=0 full=1", CTS, full);
    else n_pass++;
    n_total++;
    if (Data_out !== 32'd1) $display("FAIL full_head: Data_out=%h required 1", Data_out);
    else n_pass++;
    read_en_E = 1'b1;
    tick();
    read_en_E = 1'b0;
    n_total++;
    if (CTS !== 1'b0 || count !== 3'd3)
      $display("FAIL full_pop: CTS=%b count=%0d required CTS=0 count=3", CTS, count);
    else n_pass++;
    tick();
    n_total++;
    if (CTS !== 1'b1) $display("FAIL full_reopen: CTS=%b required 1", CTS); else n_pass++;
    tick();
    DRTS = 1'b0;
    n_total++;
    if (count !== 3'd4) $display("FAIL full_write5: count=%0d required 4", count); else n_pass++;
    for (int i = 2; i <= 5; i++) pop_n(32'(i));
    n_total++;
    if (empty !== 1'b1) $display("FAIL full_drain: empty=%b required 1", empty); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] d [6];
    d = '{32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'hC5};
    apply_reset();
    for (int i = 0; i < 3; i++) send_flit(d[i]);
    for (int i = 3; i < 6; i++) begin
      pop_n(d[i-3]);
      send_flit(d[i]);
    end
    for (int i = 3; i < 6; i++) pop_n(d[i]);
    n_total++;
    if (dut.r_rd_ptr !== 2'd2 || dut.r_wr_ptr !== 2'd2)
      $display("FAIL wrap_ptrs: rd_ptr=%0d wr_ptr=%0d required 2 and 2",
               dut.r_rd_ptr, dut.r_wr_ptr);
    else n_pass++;
    n_total++;
    if (empty !== 1'b1) $display("FAIL wrap_empty: empty=%b required 1", empty); else n_pass++;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    send_flit(32'h10);
    send_flit(32'h11);
    DRTS = 1'b1;
    RX   = 32'h12;
    tick();
    read_en_N = 1'b1;
    tick();
    read_en_N = 1'b0;
    DRTS = 1'b0;
    n_total++;
    if (count !== 3'd2) $display("FAIL simul_count: count=%0d required 2", count); else n_pass++;
    pop_n(32'h11);
    pop_n(32'h12);
  endtask

  task automatic test_empty_read();
    apply_reset();
    read_en_L = 1'b1;
    tick();
    read_en_L = 1'b0;
    n_total++;
    if (count !== 3'd0 || empty !== 1'b1 || dut.r_rd_ptr !== 2'd0)
      $display("FAIL empty_read: count=%0d empty=%b rd_ptr=%0d required 0 1 0",
               count, empty, dut.r_rd_ptr);
    else n_pass++;
    DRTS = 1'b1;
    RX   = 32'h77;
    tick();
    read_en_W = 1'b1;
    tick();
    read_en_W = 1'b0;
    DRTS = 1'b0;
    n_total++;
    if (count !== 3'd1 || dut.r_rd_ptr !== 2'd0)
      $display("FAIL empty_simul: count=%0d rd_ptr=%0d required 1 0", count, dut.r_rd_ptr);
    else n_pass++;
    n_total++;
    if (Data_out !== 32'h77) $display("FAIL empty_simul_data: Data_out=%h required 77", Data_out);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 3; i++) send_flit(32'h50 + 32'(i));
    DRTS = 1'b1;
    RX   = 32'h99;
    tick();
    n_total++;
    if (CTS !== 1'b1 || count !== 3'd3)
      $display("FAIL midrst_pre: CTS=%b count=%0d required 1 3", CTS, count);
    else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++;
    if (CTS !== 1'b0 || count !== 3'd0 || empty !== 1'b1)
      $display("FAIL midrst_post: CTS=%b count=%0d empty=%b required 0 0 1", CTS, count, empty);
    else n_pass++;
    tick();
    n_total++;
    if (CTS !== 1'b1) $display("FAIL midrst_rects: CTS=%b required 1", CTS); else n_pass++;
    tick();
    DRTS = 1'b0;
    n_total++;
    if (count !== 3'd1 || Data_out !== 32'h99)
      $display("FAIL midrst_write: count=%0d Data_out=%h required 1 99", count, Data_out);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    DRTS = 1'b0;
    RX = '0;
    read_en_N = 1'b0;
    read_en_E = 1'b0;
    read_en_W = 1'b0;
    read_en_S = 1'b0;
    read_en_L = 1'b0;
    #2;
    test_reset();
    test_single_write();
    test_fill_full();
    test_wrap();
    test_back_to_back();
    test_empty_read();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/router_input_fifo.md
Name: router_input_fifo

Overview:
- Per-port input buffer of the mesh router; one instance each on the N, E, W, S and L inputs.
- Receives flits from the upstream router (or local NI) over the DRTS/CTS two-phase handshake.
- Buffers flits in a circular FIFO and presents the head flit to the crossbar.
- Is popped by the output-port arbiters' grant pulses. The output arbiter's RTS/DCTS pair drives the DRTS/CTS pair of the downstream instance of this block.

Parameters:
DATA_WIDTH, 32, flit width in bits
DEPTH, 4, number of flit slots; power of two, >= 2
PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
DRTS  input  1  upstream request-to-send; held high by sender until CTS pulse seen
RX  input  DATA_WIDTH  incoming flit, valid while DRTS high
CTS  output  1  clear-to-send pulse back to upstream (registered)
read_en_N  input  1  grant from N output arbiter
read_en_E  input  1  grant from E output arbiter
read_en_W  input  1  grant from W output arbiter
read_en_S  input  1  grant from S output arbiter
read_en_L  input  1  grant from L output arbiter
Data_out  output  DATA_WIDTH  head flit (mem[rd_ptr]), combinational from storage
empty  output  1  count == 0
full  output  1  count == DEPTH
count  output  PTR_W+1  current occupancy

Behaviour:
- Reset values (rst high at a clock edge):
  - CTS=0, rd_ptr=0, wr_ptr=0, count=0, so empty=1 and full=0.
  - Storage contents are not reset; Data_out is don't-care while empty.
  - Reset takes priority over every other event, including a handshake in progress. A pending DRTS after reset is answered afresh.
- CTS handshake (one flit per two cycles):
  - CTS_next = 1 iff CTS==0 && DRTS==1 && full==0; otherwise CTS_next = 0.
  - CTS is therefore never high two consecutive cycles.
- Write:
  - Occurs on an edge where CTS==1 && DRTS==1.
  - mem[wr_ptr] <= RX; wr_ptr increments modulo DEPTH.
  - CTS==1 with DRTS==0 (sender withdrew) writes nothing.
- Full check:
  - Performed when CTS is raised. Occupancy between CTS rise and the write can only fall, so overflow is impossible.
  - If full, CTS stays 0 until a read frees a slot. The first cycle with full==0 and DRTS==1 raises CTS.
- Read:
  - read_en = OR of the five read_en_* inputs; at most one is high by construction.
  - Occurs on an edge where read_en==1 && empty==0: rd_ptr increments modulo DEPTH.
  - Read while empty is ignored; pointers and count are unchanged.
- Count:
  - +1 on write only, −1 on read only, unchanged on simultaneous write and read.
  - Simultaneous read and write when count==DEPTH cannot occur, because CTS is suppressed while full.
  - Simultaneous read and write when count==0: the write lands, the read is ignored (empty was 1), and count becomes 1.
- Pointer wrap: DEPTH-1 → 0 for both pointers. Ordering is strict FIFO.
- Latency:
  - A flit written at edge k is visible on Data_out after edge k (zero added read latency), provided it is at the head.
  - Upstream sees CTS one cycle after asserting DRTS (if not full).
- Matching arbiter behaviour: an arbiter holding RTS high drops it the cycle after seeing CTS, producing the DRTS high / CTS pulse / DRTS low pattern.

Test Plan:
- Reset, then DRTS=1 with RX=0xA5A5_0001: CTS=1 exactly one cycle later, then 0. mem[0]=0xA5A5_0001, count=1, empty=0, Data_out=0xA5A5_0001.
- DRTS held high continuously with RX stepping 1,2,3,4,5: CTS toggles 1,0,1,0,… Four flits are accepted, full=1 and CTS stays 0. Pulse read_en_E: CTS rises next cycle and flit 5 is written. Data_out sequence on pops is 1,2,3,4,5.
- Pointer wrap: write 6 flits and read 6, interleaved so count never exceeds 3. Data_out order equals write order; rd_ptr and wr_ptr both end at 2.
- Simultaneous write (CTS=1, DRTS=1) and read_en_N with count=2: count stays 2, head advances, new flit appended.
- read_en_L while empty, and read_en_W in the same cycle as the first write to an empty FIFO: no pointer underflow, count ends at 1, Data_out = written flit.
- rst asserted for one cycle while CTS=1 and count=3: next cycle CTS=0, count=0, empty=1. With DRTS still high, CTS=1 one cycle after rst deasserts.
